// File: rtl/pico_mem_ctrl.sv
// picorv32 native-bus slave: word RAM with read wait states, TX byte FIFO and status MMIO.
// Unmapped accesses still complete, but they set a sticky bus_err flag so the core never hangs.
module pico_mem_ctrl #(
  parameter int          MEM_WORDS    = 32768,
  parameter int          READ_LATENCY = 1,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] OUT_ADDR     = 32'h2000_0000,
  parameter logic [31:0] STAT_ADDR    = 32'h2000_0004
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_valid,
  input  logic                        mem_instr,
  output logic                        mem_ready,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_wdata,
  input  logic [3:0]                  mem_wstrb,
  output logic [31:0]                 mem_rdata,
  output logic [7:0]                  out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        bus_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [29:0] RAM_LIMIT = 30'(MEM_WORDS);
  localparam logic [2:0]  LAT       = 3'(READ_LATENCY);
  localparam logic [PW:0] DEPTH     = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  state_t        r_state;
  logic [31:0]   r_ram [MEM_WORDS];
  logic [31:0]   r_ram_q;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic [2:0]    r_wait_cnt;
  logic          r_ready;
  logic          r_sel_ram;
  logic          r_bus_err;
  logic [31:0]   r_rdata;

  logic [29:0]   w_word_idx;
  logic [AW-1:0] w_ram_idx;
  logic          w_req;
  logic          w_is_wr;
  logic          w_is_ram;
  logic          w_is_out;
  logic          w_is_stat;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [3:0]    w_lane_we;
  logic [31:0]   w_stat;
  logic          w_unused;

  assign w_word_idx = mem_addr[31:2];
  assign w_ram_idx  = mem_addr[AW+1:2];
  assign w_req      = !reset && (r_state == IDLE) && mem_valid;
  assign w_is_wr    = (mem_wstrb != 4'b0000);
  assign w_is_ram   = (w_word_idx < RAM_LIMIT);
  assign w_is_out   = !w_is_ram && (w_word_idx == OUT_ADDR[31:2]);
  assign w_is_stat  = !w_is_ram && (w_word_idx == STAT_ADDR[31:2]);
  assign w_full     = (r_level == DEPTH);
  assign w_empty    = (r_level == '0);
  // Push decision uses the registered level, so a pop frees space only for the next cycle.
  assign w_push     = w_req && w_is_out && w_is_wr && !w_full;
  assign w_pop      = !w_empty && out_ready;
  assign w_ram_we   = w_req && w_is_ram && w_is_wr;
  assign w_ram_re   = w_req && w_is_ram && !w_is_wr;
  assign w_stat     = {16'd0, 8'(r_level), 5'd0, r_bus_err, w_full, w_empty};
  assign w_unused   = ^{mem_instr, mem_addr[1:0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_we[gi] = w_ram_we && mem_wstrb[gi];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_lane_we[b]) r_ram[w_ram_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (w_ram_re) r_ram_q <= r_ram[w_ram_idx];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
      r_sel_ram  <= 1'b0;
      r_wait_cnt <= 3'd0;
      r_bus_err  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_sel_ram <= w_is_ram && !w_is_wr;
            r_rdata   <= 32'd0;
            if (w_is_ram) begin
              if (w_is_wr || LAT == 3'd0) begin
                r_state <= ACK;
                r_ready <= 1'b1;
              end else begin
                r_wait_cnt <= LAT;
                r_state    <= RD_WAIT;
              end
            end else if (w_is_out) begin
              // A write into a full FIFO holds the core in IDLE until space appears.
              if (!w_is_wr || !w_full) begin
                r_state <= ACK;
                r_ready <= 1'b1;
              end
            end else if (w_is_stat) begin
              if (!w_is_wr) r_rdata <= w_stat;
              r_state <= ACK;
              r_ready <= 1'b1;
            end else begin
              r_bus_err <= 1'b1;
              r_state   <= ACK;
              r_ready   <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (r_wait_cnt == 3'd1) begin
            r_state <= ACK;
            r_ready <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_ready  = r_ready;
  assign mem_rdata  = r_sel_ram ? r_ram_q : r_rdata;
  assign out_valid  = !w_empty;
  assign out_byte   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign bus_err    = r_bus_err;
  assign fifo_level = r_level;
endmodule

// File: tb/tb_pico_mem_ctrl.sv
// Self-checking bench for pico_mem_ctrl: directed vector table, FIFO stall and reset corners,
// then randomized traffic checked against a queue/array reference model.
module tb_pico_mem_ctrl;
  localparam int          MW     = 1024;
  localparam int          RL     = 3;
  localparam int          FD     = 16;
  localparam logic [31:0] OUT_A  = 32'h2000_0000;
  localparam logic [31:0] STAT_A = 32'h2000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic        mem_ready;
  logic        out_valid;
  logic        bus_err;
  logic [31:0] mem_rdata;
  logic [7:0]  out_byte;
  logic [$clog2(FD):0] fifo_level;

  always #5 clk = ~clk;

  pico_mem_ctrl #(
    .MEM_WORDS(MW), .READ_LATENCY(RL), .FIFO_DEPTH(FD),
    .OUT_ADDR(OUT_A), .STAT_ADDR(STAT_A)
  ) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .bus_err(bus_err),
    .fifo_level(fifo_level)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [31:0] m_mem [MW];
  logic [7:0]  m_fifo [$];
  bit          m_err = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          chk_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane RAM array, byte queue for the TX FIFO, sticky error bit.
  function automatic void model_apply(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic [31:0] er, output int el);
    int unsigned w;
    w  = a[31:2];
    er = 32'd0;
    el = 1;
    if (a < MW * 4) begin
      if (s != 4'd0) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_mem[w][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        er = m_mem[w];
        el = 1 + RL;
      end
    end else if ((a & ~32'd3) == OUT_A) begin
      if (s != 4'd0) m_fifo.push_back(d[7:0]);
    end else if ((a & ~32'd3) == STAT_A) begin
      if (s == 4'd0)
        er = {16'd0, 8'(m_fifo.size()), 5'd0, m_err, m_fifo.size() == FD, m_fifo.size() == 0};
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // Consumer: every pop must match the oldest byte the model holds.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_pops++;
      if (m_fifo.size() == 0) check("pop_unexpected", 32'(out_byte), 32'hFFFF_FFFF);
      else check("pop_byte", 32'(out_byte), 32'(m_fifo.pop_front()));
    end
  end

  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output int lat);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = 1'($urandom_range(0, 1));
    lat = -1;
    rd  = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = c;
        rd  = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(mem_ready), 32'd0);
    $display("txn addr=%h wdata=%h wstrb=%h rdata=%h lat=%0d", a, d, s, rd, lat);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 64 && out_valid; c++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_model_empty", 32'(m_fifo.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, er, a, d;
    logic [3:0]  s;
    int          lat, el, op, pops0;
    bit          seen_ready;

    vecs[0]  = '{32'h100,      32'hDEAD_BEEF, 4'hF,    32'h0,         1,      1'b0};
    vecs[1]  = '{32'h100,      32'h0,         4'h0,    32'hDEAD_BEEF, 1 + RL, 1'b1};
    vecs[2]  = '{32'h104,      32'h1122_3344, 4'hF,    32'h0,         1,      1'b0};
    vecs[3]  = '{32'h104,      32'h0000_5A00, 4'b0010, 32'h0,         1,      1'b0};
    vecs[4]  = '{32'h104,      32'h0,         4'h0,    32'h1122_5A44, 1 + RL, 1'b1};
    vecs[5]  = '{32'h106,      32'h0,         4'h0,    32'h1122_5A44, 1 + RL, 1'b1};
    vecs[6]  = '{STAT_A,       32'h0,         4'h0,    32'h0000_0001, 1,      1'b1};
    vecs[7]  = '{OUT_A,        32'h0000_0041, 4'h1,    32'h0,         1,      1'b0};
    vecs[8]  = '{OUT_A,        32'h0000_0142, 4'hF,    32'h0,         1,      1'b0};
    vecs[9]  = '{OUT_A | 32'h2, 32'h0000_0043, 4'h1,   32'h0,         1,      1'b0};
    vecs[10] = '{STAT_A,       32'h0,         4'h0,    32'h0000_0300, 1,      1'b1};
    vecs[11] = '{OUT_A,        32'h0,         4'h0,    32'h0,         1,      1'b1};
    vecs[12] = '{STAT_A,       32'hFFFF_FFFF, 4'hF,    32'h0,         1,      1'b0};
    vecs[13] = '{STAT_A,       32'h0,         4'h0,    32'h0000_0300, 1,      1'b1};
    vecs[14] = '{32'h100,      32'hAA00_0000, 4'b1000, 32'h0,         1,      1'b0};
    vecs[15] = '{32'h100,      32'h0,         4'h0,    32'hAAAD_BEEF, 1 + RL, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    foreach (vecs[i]) begin
      model_apply(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, er, el);
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    drain();

    // Fill the FIFO, then a further write must stall until the consumer frees a slot.
    for (int i = 0; i < FD; i++) begin
      d = 32'h41 + 32'(i);
      model_apply(OUT_A, d, 4'h1, er, el);
      do_access(OUT_A, d, 4'h1, rd, lat);
      check("fill_lat", 32'(lat), 32'd1);
    end
    check("full_level", 32'(fifo_level), 32'(FD));
    pops0 = n_pops;
    mem_valid = 1'b1; mem_addr = OUT_A; mem_wdata = 32'h51; mem_wstrb = 4'h1;
    seen_ready = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ready) seen_ready = 1'b1;
    end
    check("stall_no_ready", 32'(seen_ready), 32'd0);
    check("stall_level", 32'(fifo_level), 32'(FD));
    out_ready = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = c;
        break;
      end
    end
    mem_valid = 1'b0; mem_wstrb = 4'd0;
    check("stall_release_lat", 32'(lat), 32'd2);
    model_apply(OUT_A, 32'h51, 4'h1, er, el);
    @(posedge clk); #1;
    drain();
    check("stall_pop_count", 32'(n_pops - pops0), 32'(FD + 1));

    model_apply(32'h4000_0000, 32'h0, 4'h0, er, el);
    do_access(32'h4000_0000, 32'h0, 4'h0, rd, lat);
    check("unmapped_lat", 32'(lat), 32'd1);
    check("unmapped_rdata", rd, 32'd0);
    check("unmapped_bus_err", 32'(bus_err), 32'd1);
    model_apply(STAT_A, 32'h0, 4'h0, er, el);
    do_access(STAT_A, 32'h0, 4'h0, rd, lat);
    check("stat_err_bit", rd, 32'h0000_0005);
    model_apply(32'h0, 32'h1234_5678, 4'hF, er, el);
    do_access(32'h0, 32'h1234_5678, 4'hF, rd, lat);
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    for (int w = 0; w < 32; w++) begin
      d = $urandom;
      model_apply(32'(w * 4), d, 4'hF, er, el);
      do_access(32'(w * 4), d, 4'hF, rd, lat);
      check("init_lat", 32'(lat), 32'(el));
    end
    for (int t = 0; t < 250; t++) begin
      op = $urandom_range(0, 9);
      if (op == 9) begin
        out_ready = 1'b1;
        repeat ($urandom_range(1, 5)) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        continue;
      end
      d = $urandom;
      a = STAT_A;
      s = 4'h0;
      case (op)
        0, 1, 2: begin
          a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
          s = 4'($urandom_range(1, 15));
        end
        3, 4, 5: a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        6: begin
          a = OUT_A;
          if (m_fifo.size() < FD) s = 4'($urandom_range(1, 15));
        end
        7: s = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
        default: begin
          a = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
          s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
        end
      endcase
      model_apply(a, d, s, er, el);
      do_access(a, d, s, rd, lat);
      check("rand_lat", 32'(lat), 32'(el));
      if (s == 4'h0) check("rand_rdata", rd, er);
      check("rand_bus_err", 32'(bus_err), 32'(m_err));
    end
    drain();

    // Reset while a RAM read is in its wait states.
    for (int i = 0; i < 2; i++) begin
      model_apply(OUT_A, 32'h61 + 32'(i), 4'h1, er, el);
      do_access(OUT_A, 32'h61 + 32'(i), 4'h1, rd, lat);
    end
    check("pre_rst_level", 32'(fifo_level), 32'd2);
    mem_valid = 1'b1; mem_addr = 32'h100; mem_wstrb = 4'h0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("rdwait_no_ready", 32'(mem_ready), 32'd0);
    reset = 1'b1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_fifo.delete();
    m_err = 1'b0;
    seen_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready) seen_ready = 1'b1;
    end
    check("abort_no_ready", 32'(seen_ready), 32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_byte", 32'(out_byte), 32'd0);
    check("abort_bus_err", 32'(bus_err), 32'd0);
    check("abort_rdata", mem_rdata, 32'd0);
    do_access(32'h100, 32'h0, 4'h0, rd, lat);
    check("post_rst_lat", 32'(lat), 32'(1 + RL));
    check("post_rst_rdata", rd, 32'hAAAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
